// File: rtl/irq_controller.sv
// irq_controller: 6502 interrupt controller with synchronised sources, maskable pending register,
// write-1-to-clear ack and registered active-low IRQ. Define IRQ_VECTOR_EN for the vector readback.
module irq_controller #(
   parameter int         NUM_SRC   = 8,
   parameter logic [7:0] EDGE_MASK = 8'hFF,
   parameter logic [7:0] MASK_RST  = 8'h00
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               phi2,
   input  logic               rwb,
   input  logic               irq_cs,
   input  logic               mask_cs,
   input  logic [7:0]         data_in,
   output logic [7:0]         data_out,
   input  logic [NUM_SRC-1:0] src,
   output logic               irq_n
);

   localparam logic [8:0] ONE        = 9'd1;
   localparam logic [7:0] VALID_BITS = 8'((ONE << NUM_SRC) - ONE);
   localparam logic [7:0] EDGE_BITS  = EDGE_MASK & VALID_BITS;
   localparam logic [7:0] LEVEL_BITS = ~EDGE_MASK & VALID_BITS;

   logic [7:0] src_ext;
   logic [7:0] s1, s2, prev;
   logic [7:0] pending, pending_nxt;
   logic [7:0] mask, mask_nxt;
   logic [7:0] mask_rd;
   logic [7:0] data_q;
   logic [1:0] cs_q;
   logic       rwb_q, phi2_q;
   logic       commit, ack_wr, mask_wr;

   always_comb begin
      src_ext = '0;
      for (int i = 0; i < NUM_SRC; i++) src_ext[i] = src[i];
   end

   // Writes land on the phi2 falling edge using the values captured while phi2 was high.
   assign commit  = phi2_q & ~phi2 & ~rwb_q;
   assign ack_wr  = commit & cs_q[1];
   assign mask_wr = commit & ~cs_q[1] & cs_q[0];

   // A new edge in the same cycle as its ack keeps the bit set.
   assign pending_nxt = (((pending & ~(ack_wr ? data_q : 8'h00)) | (s2 & ~prev)) & EDGE_BITS)
                      | (s2 & LEVEL_BITS);
   assign mask_nxt    = mask_wr ? (data_q & VALID_BITS) : mask;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1      <= '0;
         s2      <= '0;
         prev    <= '0;
         pending <= '0;
         mask    <= MASK_RST & VALID_BITS;
         irq_n   <= 1'b1;
         phi2_q  <= 1'b0;
         cs_q    <= '0;
         rwb_q   <= 1'b0;
         data_q  <= '0;
      end else begin
         s1      <= src_ext;
         s2      <= s1;
         prev    <= s2;
         pending <= pending_nxt;
         mask    <= mask_nxt;
         irq_n   <= ~|(pending & mask & VALID_BITS);
         phi2_q  <= phi2;
         if (phi2) begin
            cs_q   <= {irq_cs, mask_cs};
            rwb_q  <= rwb;
            data_q <= data_in;
         end
      end
   end

`ifdef IRQ_VECTOR_EN
   function automatic logic [7:0] vec_encode(input logic [7:0] active);
      logic [7:0] r;
      r = 8'h00;
      for (int i = 7; i >= 0; i--) begin
         if (active[i]) r = {1'b1, 4'b0000, 3'(i)};
      end
      return r;
   endfunction

   assign mask_rd = vec_encode(pending & mask & VALID_BITS);
`else
   assign mask_rd = mask;
`endif

   always_comb begin
      data_out = 8'h00;
      if (irq_cs && rwb)       data_out = pending;
      else if (mask_cs && rwb) data_out = mask_rd;
   end

endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: table-driven register vectors plus scoreboarded and hand-written
// timing sequences for irq_controller (NUM_SRC=7, source 0 level-sensitive).
module tb_irq_controller;

   localparam int NUM_SRC = 7;
`ifdef IRQ_VECTOR_EN
   localparam bit VEC_EN = 1'b1;
`else
   localparam bit VEC_EN = 1'b0;
`endif

   logic               clk = 1'b0;
   logic               rst_n, phi2, rwb, irq_cs, mask_cs;
   logic [7:0]         data_in, data_out;
   logic [NUM_SRC-1:0] src;
   logic               irq_n;

   always #5 clk = ~clk;

   irq_controller #(.NUM_SRC(NUM_SRC), .EDGE_MASK(8'hFE), .MASK_RST(8'h00)) dut (
      .clk(clk), .rst_n(rst_n), .phi2(phi2), .rwb(rwb), .irq_cs(irq_cs), .mask_cs(mask_cs),
      .data_in(data_in), .data_out(data_out), .src(src), .irq_n(irq_n)
   );

   typedef struct packed {
      logic [1:0] sel;
      logic [7:0] wdata;
      logic [7:0] exp_mask;
   } vec_t;

   vec_t       vecs[6];
   string      name_q[$];
   logic [7:0] exp_q[$];
   int         n_vec = 0;
   int         n_err = 0;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
      end
   endtask

   task automatic sb_push(input string name, input logic [7:0] exp);
      name_q.push_back(name);
      exp_q.push_back(exp);
   endtask

   task automatic sb_pop(input logic [7:0] act);
      string      nm;
      logic [7:0] ex;
      if (exp_q.size() == 0) begin
         n_vec++;
         n_err++;
         $display("FAIL scoreboard_empty: got 0x%02h, expected a queued entry", act);
      end else begin
         nm = name_q.pop_front();
         ex = exp_q.pop_front();
         check(nm, act, ex);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic is_irq, output logic [7:0] v);
      irq_cs  = is_irq;
      mask_cs = ~is_irq;
      rwb     = 1'b1;
      #1;
      v       = data_out;
      irq_cs  = 1'b0;
      mask_cs = 1'b0;
      #1;
   endtask

   // sel = {irq_cs, mask_cs}; returns just after the commit edge.
   task automatic wr(input logic [1:0] sel, input logic [7:0] d, input logic [NUM_SRC-1:0] pulse);
      irq_cs  = sel[1];
      mask_cs = sel[0];
      rwb     = 1'b0;
      data_in = d;
      phi2    = 1'b1;
      src     = src | pulse;
      tick();
      src     = src & ~pulse;
      tick();
      phi2    = 1'b0;
      tick();
      irq_cs  = 1'b0;
      mask_cs = 1'b0;
      rwb     = 1'b1;
      data_in = 8'h00;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time bound");
      $fatal(1);
   end

   initial begin
      logic [7:0] v;
      logic [7:0] exp_st[4];
      logic [7:0] exp_irq[4];

      rst_n = 1'b0; phi2 = 1'b0; rwb = 1'b1; irq_cs = 1'b0; mask_cs = 1'b0;
      data_in = 8'h00; src = '0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();

      rd(1'b1, v); check("rst_status", v, 8'h00);
      rd(1'b0, v); check("rst_mask", v, 8'h00);
      check("rst_irq_n", {7'b0, irq_n}, 8'h01);
      check("rst_idle_bus", data_out, 8'h00);

      vecs[0] = '{2'b01, 8'h05, VEC_EN ? 8'h00 : 8'h05};
      vecs[1] = '{2'b01, 8'hFF, VEC_EN ? 8'h00 : 8'h7F};
      vecs[2] = '{2'b00, 8'h00, VEC_EN ? 8'h00 : 8'h7F};
      vecs[3] = '{2'b10, 8'hFF, VEC_EN ? 8'h00 : 8'h7F};
      vecs[4] = '{2'b01, 8'h80, 8'h00};
      vecs[5] = '{2'b01, 8'h05, VEC_EN ? 8'h00 : 8'h05};
      for (int i = 0; i < 6; i++) begin
         wr(vecs[i].sel, vecs[i].wdata, '0);
         sb_push($sformatf("vec%0d_mask", i), vecs[i].exp_mask);
         sb_push($sformatf("vec%0d_status", i), 8'h00);
         sb_push($sformatf("vec%0d_irq_n", i), 8'h01);
         tick();
         rd(1'b0, v); sb_pop(v);
         rd(1'b1, v); sb_pop(v);
         sb_pop({7'b0, irq_n});
      end

      // One-clock pulse on src[2]: pending at edge 3, irq_n low at edge 4.
      exp_st  = '{8'h00, 8'h00, 8'h04, 8'h04};
      exp_irq = '{8'h01, 8'h01, 8'h01, 8'h00};
      src = 7'h04;
      for (int e = 0; e < 4; e++) begin
         sb_push($sformatf("pulse2_status_e%0d", e + 1), exp_st[e]);
         sb_push($sformatf("pulse2_irq_n_e%0d", e + 1), exp_irq[e]);
      end
      for (int e = 0; e < 4; e++) begin
         tick();
         if (e == 0) src = '0;
         rd(1'b1, v); sb_pop(v);
         sb_pop({7'b0, irq_n});
      end

      wr(2'b10, 8'h04, '0);
      rd(1'b1, v); check("ack2_status", v, 8'h00);
      check("ack2_irq_n_same_edge", {7'b0, irq_n}, 8'h00);
      tick();
      check("ack2_irq_n_next", {7'b0, irq_n}, 8'h01);

      src = 7'h02;
      tick();
      src = '0;
      repeat (3) tick();
      rd(1'b1, v); check("masked1_status", v, 8'h02);
      check("masked1_irq_n", {7'b0, irq_n}, 8'h01);
      wr(2'b10, 8'h02, '0);
      rd(1'b1, v); check("ack1_status", v, 8'h00);

      wr(2'b01, 8'h0D, '0);
      src = 7'h08;
      tick();
      src = '0;
      repeat (3) tick();
      rd(1'b1, v); check("src3_status", v, 8'h08);
      check("src3_irq_n", {7'b0, irq_n}, 8'h00);
      wr(2'b10, 8'h08, 7'h08);
      rd(1'b1, v); check("setwins_status", v, 8'h08);
      check("setwins_irq_n", {7'b0, irq_n}, 8'h00);
      tick();
      check("setwins_irq_n_next", {7'b0, irq_n}, 8'h00);
      wr(2'b10, 8'h08, '0);
      rd(1'b1, v); check("ack3_status", v, 8'h00);
      tick();
      check("ack3_irq_n", {7'b0, irq_n}, 8'h01);

      // Level source 0.
      src = 7'h01;
      repeat (2) tick();
      rd(1'b1, v); check("lvl_status_e2", v, 8'h00);
      tick();
      rd(1'b1, v); check("lvl_status_e3", v, 8'h01);
      tick();
      check("lvl_irq_n", {7'b0, irq_n}, 8'h00);
      wr(2'b10, 8'h01, '0);
      rd(1'b1, v); check("lvl_ack_ignored", v, 8'h01);
      src = '0;
      repeat (2) tick();
      rd(1'b1, v); check("lvl_drop_e2", v, 8'h01);
      tick();
      rd(1'b1, v); check("lvl_drop_e3", v, 8'h00);
      check("lvl_drop_irq_n_e3", {7'b0, irq_n}, 8'h00);
      tick();
      check("lvl_drop_irq_n_e4", {7'b0, irq_n}, 8'h01);

      wr(2'b01, 8'hFF, '0);
      src = 7'h28;
      tick();
      src = '0;
      repeat (3) tick();
      rd(1'b1, v); check("vec_status", v, 8'h28);
      rd(1'b0, v); check("vec_read_28", v, VEC_EN ? 8'h83 : 8'h7F);
      check("vec_irq_n", {7'b0, irq_n}, 8'h00);
      wr(2'b10, 8'h08, '0);
      rd(1'b1, v); check("vec_status_20", v, 8'h20);
      rd(1'b0, v); check("vec_read_20", v, VEC_EN ? 8'h85 : 8'h7F);
      wr(2'b10, 8'h20, '0);
      rd(1'b0, v); check("vec_read_00", v, VEC_EN ? 8'h00 : 8'h7F);
      tick();
      check("vec_irq_n_clear", {7'b0, irq_n}, 8'h01);

      // Reset while everything is pending, with sources held through release.
      src = 7'h7F;
      repeat (4) tick();
      rd(1'b1, v); check("prerst_status", v, 8'h7F);
      check("prerst_irq_n", {7'b0, irq_n}, 8'h00);
      rst_n = 1'b0;
      tick();
      rd(1'b1, v); check("midrst_status", v, 8'h00);
      rd(1'b0, v); check("midrst_mask", v, 8'h00);
      check("midrst_irq_n", {7'b0, irq_n}, 8'h01);
      check("midrst_data_out", data_out, 8'h00);
      rst_n = 1'b1;
      repeat (2) tick();
      rd(1'b1, v); check("rel_status_e2", v, 8'h00);
      tick();
      rd(1'b1, v); check("rel_status_e3", v, 8'h7F);
      tick();
      check("rel_irq_n_masked", {7'b0, irq_n}, 8'h01);
      src = '0;

      if (exp_q.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL scoreboard_leftover: got %0d entries, expected 0", exp_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
